req_delay_responder: RTL and testbench

Programmable-latency request responder: every cycle in which `a` is sampled high produces exactly one single-cycle pulse on `b`, sampled high exactly `D` rising edges later. It is the design-under-test stage that drives the `a |-> ##D b` checkers in our assertion benches. It replaces hand-written task stimulus with a real sequential source. It tracks overlapping requests, counts responses, and supports runtime latency reconfiguration and flush.

---
 rtl/req_delay_pkg.sv | 15 +
 rtl/req_delay_line.sv | 45 ++++
 rtl/req_delay_responder.sv | 101 ++++++++++
 tb/tb_req_delay_responder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/req_delay_pkg.sv
// Shared types and constants for the programmable-latency request responder.
package req_delay_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int unsigned DEFAULT_DELAY = 2;

    function automatic int unsigned delay_w(input int unsigned max_delay);
        return $clog2(max_delay + 1);
    endfunction

endpackage

// File: rtl/req_delay_line.sv
// One-bit shift stages with a variable insert tap; stage 0 is the response output.
module req_delay_line #(
    parameter int unsigned MAX_DELAY = 8,
    parameter int unsigned DELAY_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               ins,
    input  logic [DELAY_W-1:0] tap,
    output logic               b,
    output logic               empty_next
);

    logic [MAX_DELAY-1:0] stage_q;
    logic [MAX_DELAY-1:0] stage_d;
    logic [MAX_DELAY-1:0] shifted;
    int unsigned          tap_i;

    // Clear happens before insert, so a request arriving with clear still lands at the tap.
    always_comb begin
        stage_d = '0;
        shifted = stage_q >> 1;
        tap_i   = {{(32-DELAY_W){1'b0}}, tap};
        for (int unsigned i = 0; i < MAX_DELAY; i++) begin
            if (i + 1 == tap_i) begin
                stage_d[i] = ins;
            end else if (!clear && (i + 1 < tap_i)) begin
                stage_d[i] = shifted[i];
            end
        end
    end

    assign empty_next = (stage_d == '0);
    assign b          = stage_q[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

endmodule

// File: rtl/req_delay_responder.sv
// Request responder: each sampled `a` yields one `b` pulse D edges later, with
// runtime latency reconfiguration, flush, outstanding count and response counter.
module req_delay_responder #(
    parameter int unsigned MAX_DELAY     = 8,
    parameter int unsigned DEFAULT_DELAY = req_delay_pkg::DEFAULT_DELAY,
    parameter int unsigned CNT_W         = 16,
    localparam int unsigned DELAY_W      = req_delay_pkg::delay_w(MAX_DELAY)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               a,
    input  logic               flush,
    input  logic               cfg_we,
    input  logic [DELAY_W-1:0] cfg_delay,
    output logic               b,
    output logic               busy,
    output logic [DELAY_W-1:0] pending,
    output logic [CNT_W-1:0]   resp_cnt,
    output logic               cfg_err,
    output logic [DELAY_W-1:0] delay_q
);

    import req_delay_pkg::*;

    localparam logic [DELAY_W-1:0] MAX_D = DELAY_W'(MAX_DELAY);
    localparam logic [DELAY_W-1:0] DEF_D = DELAY_W'(DEFAULT_DELAY);

    state_t             state_q;
    state_t             state_d;
    logic               line_b;
    logic               line_empty_next;
    logic               cfg_accept;
    logic               cfg_reject;
    logic [DELAY_W-1:0] pending_d;

    req_delay_line #(
        .MAX_DELAY (MAX_DELAY),
        .DELAY_W   (DELAY_W)
    ) u_line (
        .clk        (clk),
        .rst        (rst),
        .clear      (flush),
        .ins        (a),
        .tap        (delay_q),
        .b          (line_b),
        .empty_next (line_empty_next)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (a) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (flush && !a)          state_d = IDLE;
                else if (line_empty_next) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Latency may only change while the line is empty, so no bit ever sits above the tap.
    always_comb begin
        cfg_accept = cfg_we && !flush && (state_q == IDLE) && !a &&
                     (cfg_delay != '0) && (cfg_delay <= MAX_D);
        cfg_reject = cfg_we && !cfg_accept;
    end

    // Outstanding count covers every set stage, including the one currently driving `b`.
    always_comb begin
        pending_d = pending;
        if (flush) begin
            pending_d = DELAY_W'(a);
        end else if (a && !line_b) begin
            pending_d = pending + DELAY_W'(1);
        end else if (!a && line_b) begin
            pending_d = pending - DELAY_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            delay_q  <= DEF_D;
            pending  <= '0;
            resp_cnt <= '0;
            cfg_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            pending <= pending_d;
            cfg_err <= cfg_reject;
            if (cfg_accept) delay_q <= cfg_delay;
            if (line_b && (resp_cnt != '1)) resp_cnt <= resp_cnt + CNT_W'(1);
        end
    end

    assign b    = line_b;
    assign busy = (state_q == ACTIVE);

endmodule

// File: tb/tb_req_delay_responder.sv
// Scoreboard bench for req_delay_responder: stimulus pushes expected pulse edges,
// a negedge monitor checks `b` every cycle; directed checks cover the other outputs.
module tb_req_delay_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a = 1'b0;
    logic       flush = 1'b0;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_delay = 4'd0;

    logic       b, busy, cfg_err;
    logic [3:0] pending, delay_q;
    logic [15:0] resp_cnt;

    logic       b2, busy2, cfg_err2;
    logic [3:0] pending2, delay_q2;
    logic [1:0] resp_cnt2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int mdl_d = 2;
    int q[$];
    logic mon_en = 1'b0;
    logic exp_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    req_delay_responder #(.MAX_DELAY(8), .DEFAULT_DELAY(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .a(a), .flush(flush), .cfg_we(cfg_we), .cfg_delay(cfg_delay),
        .b(b), .busy(busy), .pending(pending), .resp_cnt(resp_cnt), .cfg_err(cfg_err),
        .delay_q(delay_q)
    );

    req_delay_responder #(.MAX_DELAY(8), .DEFAULT_DELAY(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .a(a), .flush(flush), .cfg_we(cfg_we), .cfg_delay(cfg_delay),
        .b(b2), .busy(busy2), .pending(pending2), .resp_cnt(resp_cnt2), .cfg_err(cfg_err2),
        .delay_q(delay_q2)
    );

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Inputs change 2 time units after negedge; the monitor has already run by then.
    task automatic drive(input logic ia, input logic ifl, input logic iwe,
                         input logic [3:0] icd, input logic irst);
        @(negedge clk);
        #2;
        a = ia; flush = ifl; cfg_we = iwe; cfg_delay = icd; rst = irst;
        if (irst) begin
            q.delete();
        end else begin
            if (ifl) q.delete();
            if (ia) q.push_back(cyc + mdl_d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            exp_b = (q.size() > 0) && (q[0] == cyc);
            checks++;
            if (b !== exp_b) begin
                errors++;
                $display("FAIL b_pulse: got %b expected %b at edge %0d", b, exp_b, cyc);
            end
            if (exp_b) void'(q.pop_front());
        end
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        chk("rst_b", b, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pending", pending, 0);
        chk("rst_resp_cnt", resp_cnt, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_delay_q", delay_q, 2);
        mon_en = 1'b1;
        idle(2);

        // single request, default D=2
        drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("single_pending_acc", pending, 1);
        chk("single_busy_acc", busy, 1);
        idle(1);
        chk("single_b_high", b, 1);
        idle(1);
        chk("single_pending_done", pending, 0);
        chk("single_busy_done", busy, 0);
        chk("single_resp_cnt", resp_cnt, 1);

        // burst of 4, pending peaks at D
        drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("burst_pending1", pending, 1);
        drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("burst_pending2", pending, 2);
        drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("burst_pending3", pending, 2);
        drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("burst_pending4", pending, 2);
        idle(1);
        chk("burst_pending5", pending, 1);
        idle(2);
        chk("burst_pending_end", pending, 0);
        chk("burst_busy_end", busy, 0);
        chk("burst_resp_cnt", resp_cnt, 5);

        // reconfigure to D=5 while idle
        drive(1'b0, 1'b0, 1'b1, 4'd5, 1'b0);
        chk("cfg5_delay_q", delay_q, 5);
        chk("cfg5_cfg_err", cfg_err, 0);
        mdl_d = 5;
        drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        idle(6);
        chk("cfg5_resp_cnt", resp_cnt, 6);

        // rejected writes
        drive(1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        chk("cfg0_err", cfg_err, 1);
        chk("cfg0_delay_q", delay_q, 5);
        idle(1);
        chk("cfg_err_clears", cfg_err, 0);
        drive(1'b0, 1'b0, 1'b1, 4'd9, 1'b0);
        chk("cfg9_err", cfg_err, 1);
        chk("cfg9_delay_q", delay_q, 5);
        drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("cfg_active_pending", pending, 1);
        drive(1'b0, 1'b0, 1'b1, 4'd3, 1'b0);
        chk("cfg_active_err", cfg_err, 1);
        chk("cfg_active_delay_q", delay_q, 5);
        idle(6);
        chk("cfg_active_resp_cnt", resp_cnt, 7);
        drive(1'b1, 1'b0, 1'b1, 4'd2, 1'b0);
        chk("cfg_with_a_err", cfg_err, 1);
        chk("cfg_with_a_delay_q", delay_q, 5);
        idle(6);
        chk("cfg_with_a_resp_cnt", resp_cnt, 8);

        // flush mid-flight, D=4
        drive(1'b0, 1'b0, 1'b1, 4'd4, 1'b0);
        chk("cfg4_delay_q", delay_q, 4);
        mdl_d = 4;
        drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("flush_pre_pending", pending, 2);
        drive(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("flush_pending", pending, 1);
        chk("flush_busy", busy, 1);
        idle(6);
        chk("flush_resp_cnt", resp_cnt, 9);
        chk("flush_busy_end", busy, 0);

        // reset during a burst
        drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        mdl_d = 2;
        chk("midrst_b", b, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_pending", pending, 0);
        chk("midrst_resp_cnt", resp_cnt, 0);
        chk("midrst_delay_q", delay_q, 2);

        // first request right after reset, 5 pulses saturate the 2-bit counter
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        idle(4);
        chk("sat_resp_cnt_wide", resp_cnt, 5);
        chk("sat_resp_cnt_narrow", resp_cnt2, 3);
        chk("scoreboard_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
